mandelbrot_param_writer: RTL
============================

// Module: mandelbrot_param_writer
// PURPOSE
//   Host-side driver for the Mandelbrot core's parameter-load pins. Queues (sel, value) write requests and
//   replays each one on the 16-bit pin bus: ui_in = {value[4:0], ctrl[2:0]}, uio_in = value[12:5].
//   Sits in the FPGA/host harness or a test bench, driving the core's inputs. Uses setup/strobe/gap timing,
//   so the core samples a settled value while ctrl is non-zero.
// PARAMETERS
//   FIFO_DEPTH   4   request queue entries; power of two, >=2
//   HOLD_CYCLES  2   cycles ctrl = sel is held (>=1)
//   GAP_CYCLES   1   cycles of ctrl = 0 after each strobe (>=1)
//   VSYNC_POL    1   active level of vsync_in (used only with VSYNC_GATE_EN)
// PORTS
//   clk        in   1   clock
//   rst_n      in   1   reset; asynchronous assert, active-low
//   req_valid  in   1   write request present
//   req_ready  out  1   = !fifo_full; request accepted on edge where valid & ready
//   req_sel    in   3   ctrl code to strobe; 0 is reserved for idle
//   req_value  in   13  signed parameter value
//   vsync_in   in   1   vsync from core (uo_out[3]); ignored without VSYNC_GATE_EN
//   ui_out     out  8   to core ui_in: {value[4:0], ctrl[2:0]}
//   uio_out    out  8   to core uio_in: value[12:5]
//   busy       out  1   state != IDLE or FIFO non-empty
//   dropped    out  1   one-cycle pulse when a sel==0 request is accepted and discarded
// BEHAVIOUR
//   Reset (asynchronous): FIFO emptied, state = IDLE, value_q = 0, ctrl = 0, counters = 0.
//     Outputs during and after reset: ui_out = 0, uio_out = 0, busy = 0, dropped = 0, req_ready = 1.
//     Reset mid-strobe aborts the write immediately, with no further strobe.
//   FIFO: synchronous push/pop. Requests with sel == 0 are not pushed; they pulse dropped on the next cycle.
//     When full, req_ready = 0 even if a pop occurs in the same cycle.
//   FSM (registered outputs):
//     IDLE:   ctrl = 0, value held. FIFO non-empty (and gate open): pop, load value_q/sel_q -> SETUP.
//     SETUP:  1 cycle; uio_out/ui_out[7:3] show new value, ctrl = 0 -> STROBE.
//     STROBE: HOLD_CYCLES cycles with ctrl = sel_q, value unchanged -> GAP.
//     GAP:    GAP_CYCLES cycles with ctrl = 0, value unchanged.
//             Then -> SETUP if FIFO non-empty (and gate open), else -> IDLE.
//   Value bits never change while ctrl != 0. After a write, the value pins keep the last value; they are not zeroed.
//   Latency: request accepted at edge E into an empty, idle writer -> SETUP visible after E+1,
//     ctrl != 0 after E+2. Steady-state strobe period = 1 + HOLD_CYCLES + GAP_CYCLES.
//   Ordering: writes are strobed exactly once each, in acceptance order.
//   value wraps in 13-bit two's complement; no sign extension or saturation.
// CONFIGURATION
//   VSYNC_GATE_EN defined:
//     vsync_in passes through a 2-flop synchroniser. The IDLE->SETUP and GAP->SETUP transitions
//       happen only while the synchronised vsync == VSYNC_POL.
//     A write already past SETUP completes even if vsync deasserts.
//     busy stays 1 while writes wait for the gate.
//   VSYNC_GATE_EN undefined: vsync_in is unused, the gate is always open, and there are no synchroniser flops.
// TESTING
//   1 reset: rst_n low mid-run -> ui_out = 0x00, uio_out = 0x00, req_ready = 1, busy = 0, immediately.
//   2 single write sel=3, value=-1 (0x1FFF), HOLD=2, GAP=1, queue otherwise empty:
//     ui_out sequence 0xF8 (SETUP), 0xFB, 0xFB, 0xF8; uio_out = 0xFF throughout; busy low after the GAP cycle.
//   3 sel=5, value=0x0A5A -> ui_out 0xD0 then 0xD5 x2 then 0xD0; uio_out = 0x52.
//   4 six back-to-back requests, valid held high:
//     req_ready drops when 4 entries are pending; all 6 are strobed in order, one per 4 cycles, no duplicates.
//   5 sel=0, value=0x0123 -> dropped pulses once; ctrl stays 0; no SETUP; value pins unchanged.
//   6 VSYNC_GATE_EN, VSYNC_POL=1: queue a write with vsync_in=0 for 100 cycles -> ctrl stays 0, busy = 1.
//     Raise vsync_in -> SETUP 3 cycles later, then a normal strobe.
//     Drop vsync mid-STROBE -> the write still completes.

Source files
------------

// File: rtl/mandelbrot_param_writer.sv
// Queues (sel, value) parameter writes and replays each on the Mandelbrot core's pin bus with setup/strobe/gap timing.
// Optional feature macro: VSYNC_GATE_EN (starts of writes wait for the synchronised vsync level VSYNC_POL).
module mandelbrot_param_writer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1,
  parameter int VSYNC_POL   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_sel,
  input  logic [12:0] req_value,
  input  logic        vsync_in,
  output logic [7:0]  ui_out,
  output logic [7:0]  uio_out,
  output logic        busy,
  output logic        dropped
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

  state_t       state_reg;
  logic [7:0]   cnt_reg;
  logic [12:0]  value_reg;
  logic [2:0]   sel_reg;
  logic [2:0]   ctrl_reg;
  logic         dropped_reg;

  logic [15:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]  count_reg;

  logic full, empty, accept, push, pop, gate_open, can_start;
  logic [15:0] head;

  assign full      = (count_reg == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && (req_sel != 3'd0);
  assign head      = mem[rd_ptr_reg];

`ifdef VSYNC_GATE_EN
  logic [1:0] vsync_sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vsync_sync_reg <= 2'b00;
    else        vsync_sync_reg <= {vsync_sync_reg[0], vsync_in};
  end

  assign gate_open = (vsync_sync_reg[1] == 1'(VSYNC_POL));
`else
  logic unused_vsync;
  assign unused_vsync = vsync_in ^ 1'(VSYNC_POL);
  assign gate_open    = 1'b1;
`endif

  assign can_start = !empty && gate_open;
  // A new write may only begin from IDLE or at the last GAP cycle.
  assign pop = can_start &&
               ((state_reg == IDLE) || ((state_reg == GAP) && (cnt_reg == GAP_LAST)));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {req_sel, req_value};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      dropped_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg   <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
      dropped_reg <= accept && (req_sel == 3'd0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      value_reg <= '0;
      sel_reg   <= '0;
      ctrl_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          ctrl_reg <= 3'd0;
          if (pop) begin
            value_reg <= head[12:0];
            sel_reg   <= head[15:13];
            state_reg <= SETUP;
          end
        end
        SETUP: begin
          ctrl_reg  <= sel_reg;
          cnt_reg   <= '0;
          state_reg <= STROBE;
        end
        STROBE: begin
          if (cnt_reg == HOLD_LAST) begin
            ctrl_reg  <= 3'd0;
            cnt_reg   <= '0;
            state_reg <= GAP;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        GAP: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg <= '0;
            if (pop) begin
              value_reg <= head[12:0];
              sel_reg   <= head[15:13];
              state_reg <= SETUP;
            end else begin
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ui_out  = {value_reg[4:0], ctrl_reg};
  assign uio_out = value_reg[12:5];
  assign busy    = (state_reg != IDLE) || !empty;
  assign dropped = dropped_reg;

endmodule
